// File: rtl/stack_ptr_ctrl_pkg.sv
// Shared types for the APCPU stack-pointer controller: op codes, fault codes, FSM states.
// Optional feature macro used across the block: SP_BANKED_EN (user/kernel SP banks).
package apcpu_sp_pkg;

  typedef enum logic [1:0] {
    SP_NOP  = 2'b00,
    SP_PUSH = 2'b01,
    SP_POP  = 2'b10,
    SP_SET  = 2'b11
  } sp_op_t;

  typedef enum logic [1:0] {
    FLT_NONE = 2'b00,
    FLT_OVF  = 2'b01,
    FLT_UNF  = 2'b10,
    FLT_SET  = 2'b11
  } sp_fault_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } sp_state_t;

  // Width of a counter able to hold 0..d inclusive.
  function automatic int unsigned depth_w(input int unsigned d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/stack_ptr_ctrl_if.sv
// Op handshake / status / LSU request bundle for stack_ptr_ctrl.
// With SP_BANKED_EN defined an sp_bank select (0 user, 1 kernel) is added.
interface stack_ptr_ctrl_if #(
  parameter int unsigned SP_WIDTH = 32,
  parameter int unsigned DEPTH    = 1024
);
  import apcpu_sp_pkg::*;
  localparam int unsigned DW = depth_w(DEPTH);

  logic                op_valid;
  logic                op_ready;
  logic [1:0]          sp_op;
  logic [SP_WIDTH-1:0] sp_set;
  logic                fault_clr;
`ifdef SP_BANKED_EN
  logic                sp_bank;
`endif
  logic [SP_WIDTH-1:0] sp_out;
  logic [DW-1:0]       depth;
  logic                full;
  logic                empty;
  logic                mem_req;
  logic                mem_we;
  logic [SP_WIDTH-1:0] mem_addr;
  logic                fault;
  logic [1:0]          fault_code;

`ifdef SP_BANKED_EN
  modport master (output op_valid, sp_op, sp_set, fault_clr, sp_bank,
                  input  op_ready, sp_out, depth, full, empty, mem_req, mem_we,
                         mem_addr, fault, fault_code);
  modport slave  (input  op_valid, sp_op, sp_set, fault_clr, sp_bank,
                  output op_ready, sp_out, depth, full, empty, mem_req, mem_we,
                         mem_addr, fault, fault_code);
`else
  modport master (output op_valid, sp_op, sp_set, fault_clr,
                  input  op_ready, sp_out, depth, full, empty, mem_req, mem_we,
                         mem_addr, fault, fault_code);
  modport slave  (input  op_valid, sp_op, sp_set, fault_clr,
                  output op_ready, sp_out, depth, full, empty, mem_req, mem_we,
                         mem_addr, fault, fault_code);
`endif

endinterface

// File: rtl/stack_ptr_ctrl_range_chk.sv
// Combinational SET validation (slot alignment and legal window) and the
// depth implied by a new SP value in an empty-descending stack.
module sp_range_chk
  import apcpu_sp_pkg::*;
#(
  parameter int unsigned         SP_WIDTH   = 32,
  parameter logic [SP_WIDTH-1:0] STACK_BASE = SP_WIDTH'(32'h0000_FFFC),
  parameter int unsigned         DEPTH      = 1024,
  parameter int unsigned         STEP_LOG2  = 2
) (
  input  logic [SP_WIDTH-1:0]        i_sp_set,
  output logic                       o_ok,
  output logic [depth_w(DEPTH)-1:0]  o_depth
);
  localparam int unsigned         DW        = depth_w(DEPTH);
  localparam logic [SP_WIDTH-1:0] STEP_MASK = (SP_WIDTH'(1) << STEP_LOG2) - SP_WIDTH'(1);
  localparam logic [SP_WIDTH-1:0] LOW_SLOT  = STACK_BASE - SP_WIDTH'((DEPTH - 1) << STEP_LOG2);

  logic [SP_WIDTH-1:0] w_diff;

  assign w_diff  = STACK_BASE - i_sp_set;
  assign o_ok    = ((i_sp_set & STEP_MASK) == '0) &&
                   (i_sp_set <= STACK_BASE) && (i_sp_set >= LOW_SLOT);
  assign o_depth = DW'(w_diff >> STEP_LOG2);

endmodule

// File: rtl/stack_ptr_ctrl.sv
// APCPU stack-pointer controller: empty-descending stack, op handshake, sticky FAULT,
// registered LSU request. Define SP_BANKED_EN for separate user/kernel SP banks.
module stack_ptr_ctrl
  import apcpu_sp_pkg::*;
#(
  parameter int unsigned         SP_WIDTH   = 32,
  parameter logic [SP_WIDTH-1:0] STACK_BASE = SP_WIDTH'(32'h0000_FFFC),
  parameter int unsigned         DEPTH      = 1024,
  parameter int unsigned         STEP_LOG2  = 2
) (
  input logic             clk,
  input logic             rst,
  stack_ptr_ctrl_if.slave bus
);
  localparam int unsigned         DW        = depth_w(DEPTH);
  localparam logic [SP_WIDTH-1:0] STEP      = SP_WIDTH'(1) << STEP_LOG2;
  localparam logic [DW-1:0]       DEPTH_MAX = DW'(DEPTH);

  sp_state_t           r_state;
  sp_fault_t           r_fault_code;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [SP_WIDTH-1:0] r_mem_addr;

  sp_op_t              w_op;
  logic                w_accept;
  logic                w_full;
  logic                w_empty;
  logic                w_set_ok;
  logic [DW-1:0]       w_set_depth;
  logic [SP_WIDTH-1:0] w_sp;
  logic [DW-1:0]       w_depth;
  logic                w_upd;
  logic [SP_WIDTH-1:0] w_sp_nxt;
  logic [DW-1:0]       w_depth_nxt;

  assign w_op     = sp_op_t'(bus.sp_op);
  assign w_accept = bus.op_valid && (r_state == ST_RUN);
  assign w_full   = (w_depth == DEPTH_MAX);
  assign w_empty  = (w_depth == '0);

  sp_range_chk #(
    .SP_WIDTH   (SP_WIDTH),
    .STACK_BASE (STACK_BASE),
    .DEPTH      (DEPTH),
    .STEP_LOG2  (STEP_LOG2)
  ) u_range_chk (
    .i_sp_set (bus.sp_set),
    .o_ok     (w_set_ok),
    .o_depth  (w_set_depth)
  );

  always_comb begin
    w_upd       = 1'b0;
    w_sp_nxt    = w_sp;
    w_depth_nxt = w_depth;
    if (w_accept) begin
      case (w_op)
        SP_PUSH: if (!w_full) begin
          w_upd       = 1'b1;
          w_sp_nxt    = w_sp - STEP;
          w_depth_nxt = w_depth + DW'(1);
        end
        SP_POP: if (!w_empty) begin
          w_upd       = 1'b1;
          w_sp_nxt    = w_sp + STEP;
          w_depth_nxt = w_depth - DW'(1);
        end
        SP_SET: if (w_set_ok) begin
          w_upd       = 1'b1;
          w_sp_nxt    = bus.sp_set;
          w_depth_nxt = w_set_depth;
        end
        default: ;
      endcase
    end
  end

`ifdef SP_BANKED_EN
  logic [SP_WIDTH-1:0] r_sp    [2];
  logic [DW-1:0]       r_depth [2];

  assign w_sp    = r_sp[bus.sp_bank];
  assign w_depth = r_depth[bus.sp_bank];

  // Only the selected bank moves; the other keeps its pointer untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp[0]    <= STACK_BASE;
      r_sp[1]    <= STACK_BASE;
      r_depth[0] <= '0;
      r_depth[1] <= '0;
    end else if (w_upd) begin
      r_sp[bus.sp_bank]    <= w_sp_nxt;
      r_depth[bus.sp_bank] <= w_depth_nxt;
    end
  end
`else
  logic [SP_WIDTH-1:0] r_sp;
  logic [DW-1:0]       r_depth;

  assign w_sp    = r_sp;
  assign w_depth = r_depth;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp    <= STACK_BASE;
      r_depth <= '0;
    end else if (w_upd) begin
      r_sp    <= w_sp_nxt;
      r_depth <= w_depth_nxt;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_fault_code <= FLT_NONE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      r_mem_req <= 1'b0;
      case (r_state)
        ST_RUN: if (bus.op_valid) begin
          case (w_op)
            SP_PUSH: if (w_full) begin
              r_state      <= ST_FAULT;
              r_fault_code <= FLT_OVF;
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_we   <= 1'b1;
              r_mem_addr <= w_sp;
            end
            SP_POP: if (w_empty) begin
              r_state      <= ST_FAULT;
              r_fault_code <= FLT_UNF;
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_we   <= 1'b0;
              r_mem_addr <= w_sp + STEP;
            end
            SP_SET: if (!w_set_ok) begin
              r_state      <= ST_FAULT;
              r_fault_code <= FLT_SET;
            end
            default: ;
          endcase
        end
        ST_FAULT: if (bus.fault_clr) begin
          r_state      <= ST_RUN;
          r_fault_code <= FLT_NONE;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign bus.op_ready   = (r_state == ST_RUN);
  assign bus.fault      = (r_state == ST_FAULT);
  assign bus.fault_code = r_fault_code;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.sp_out     = w_sp;
  assign bus.depth      = w_depth;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;

endmodule
